// File: rtl/serial_borrow_subtractor.sv
// Chunked ripple-borrow subtractor: diff = a - b - borrow_in - dec_en, CHUNK bits per clock,
// with valid/ready handshakes on both sides.
module serial_borrow_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    input  logic             dec_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);

    localparam int unsigned N_CHUNKS = WIDTH / CHUNK;
    localparam int unsigned IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int unsigned T_W      = CHUNK + 2;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
            $error("serial_borrow_subtractor: CHUNK must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   a_q, a_n;
    logic [WIDTH-1:0]   b_q, b_n;
    logic [WIDTH-1:0]   res_q, res_n;
    logic [1:0]         br_q, br_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [WIDTH-1:0]   diff_q, diff_n;
    logic               bo_q, bo_n;
    logic               in_ready_q, in_ready_n;
    logic               out_valid_q, out_valid_n;
    logic               busy_q, busy_n;

    logic [T_W-1:0]     t_c;
    logic [CHUNK-1:0]   d_c;
    logic [1:0]         br_next_c;

    // One chunk step; the two bits above the chunk hold -(borrows taken) in two's complement.
    always_comb begin
        t_c       = T_W'(a_q[CHUNK-1:0]) - T_W'(b_q[CHUNK-1:0]) - T_W'(br_q);
        d_c       = t_c[CHUNK-1:0];
        br_next_c = 2'b00 - t_c[T_W-1:CHUNK];
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n     = state_q;
        a_n         = a_q;
        b_n         = b_q;
        res_n       = res_q;
        br_n        = br_q;
        idx_n       = idx_q;
        diff_n      = diff_q;
        bo_n        = bo_q;
        in_ready_n  = in_ready_q;
        out_valid_n = out_valid_q;
        busy_n      = busy_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_n    = BUSY;
                    a_n        = a;
                    b_n        = b;
                    br_n       = 2'(borrow_in) + 2'(dec_en);
                    idx_n      = '0;
                    in_ready_n = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            BUSY: begin
                a_n   = a_q >> CHUNK;
                b_n   = b_q >> CHUNK;
                res_n = (res_q >> CHUNK) | (WIDTH'(d_c) << (WIDTH - CHUNK));
                br_n  = br_next_c;
                idx_n = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N_CHUNKS - 1)) begin
                    state_n     = DONE;
                    diff_n      = res_n;
                    bo_n        = (br_next_c != 2'b00);
                    out_valid_n = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n     = IDLE;
                    out_valid_n = 1'b0;
                    in_ready_n  = 1'b1;
                    busy_n      = 1'b0;
                end
            end
            default: begin
                state_n     = IDLE;
                out_valid_n = 1'b0;
                in_ready_n  = 1'b1;
                busy_n      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            br_q        <= '0;
            idx_q       <= '0;
            diff_q      <= '0;
            bo_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            a_q         <= a_n;
            b_q         <= b_n;
            res_q       <= res_n;
            br_q        <= br_n;
            idx_q       <= idx_n;
            diff_q      <= diff_n;
            bo_q        <= bo_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
            busy_q      <= busy_n;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign diff       = diff_q;
    assign borrow_out = bo_q;
    assign busy       = busy_q;

endmodule
